wb_lsu_queue: RTL and testbench
===============================

Name: wb_lsu_queue

Overview:
- Parametrised writeback stage with a DEPTH-entry in-order queue of outstanding load metadata, so the LSU can have several loads in flight.
- Each returning load response is aligned, sign/zero-extended for any XLEN, and arbitrated against EX results onto a single registered register-file write port (to DEC).
- Supports flush with drain of stale responses, and error-response suppression.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- DEPTH, 4, maximum outstanding loads; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid_i  in  1  EX result available this cycle
- ex_we_rd_i  in  1  EX result writes rd
- ex_rd_addr_i  in  5  EX destination register
- ex_result_i  in  XLEN  EX result data
- ex_ready_o  out  1  EX result accepted this cycle
- ld_req_valid_i  in  1  load issued to bus
- ld_req_ready_o  out  1  queue can accept a load
- ld_req_rd_addr_i  in  5  load destination register
- ld_req_width_i  in  3  funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- ld_req_offset_i  in  $clog2(XLEN/8)  byte offset, addr[k-1:0]
- ld_rsp_valid_i  in  1  load data returned, in issue order
- ld_rsp_ready_o  out  1  response accepted
- ld_rsp_data_i  in  XLEN  raw bus word
- ld_rsp_err_i  in  1  bus error on this response
- flush_i  in  1  discard all outstanding loads
- wb_valid_o  out  1  writeback valid (registered)
- wb_we_rd_o  out  1  register-file write enable
- wb_rd_addr_o  out  5  register-file address
- wb_rd_data_o  out  XLEN  register-file data
- ld_err_o  out  1  one-cycle pulse: load error, rd not written
- pending_o  out  $clog2(DEPTH)+1  live entries in queue

Behaviour:
- Reset:
  - Queue empty; pointers, count and discard counter are 0.
  - wb_valid_o, wb_we_rd_o, wb_rd_addr_o, wb_rd_data_o, ld_err_o are all 0.
- Queue:
  - Circular FIFO holding {rd_addr, width, offset}. Push on ld_req_valid_i && ld_req_ready_o.
  - ld_req_ready_o = !full && !flush_i. No push-while-full, even with a simultaneous pop.
  - Pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged.
- Response acceptance:
  - ld_rsp_ready_o = (count != 0) || (discard != 0).
  - A response with an empty queue and discard == 0 is not accepted and has no effect.
- Discard handling: if discard != 0, an accepted response decrements discard and produces no writeback and no error pulse. Head entries are not popped.
- Flush:
  - In the flush cycle: discard <= discard + count, counting only entries still live after that cycle's pop, and not counting a response consumed that cycle. Then count and pointers reset to 0.
  - Pushes are blocked during flush.
  - An EX result in the flush cycle is still accepted; EX is responsible for invalidating it.
- Arbitration:
  - A live load response (accepted, discard == 0) has priority over EX.
  - ex_ready_o = !(ld_rsp_valid_i && discard == 0 && count != 0).
- Load formatting:
  - shifted = data >> (8*offset). Extension by width:
    - B / BU: 8 bits, sign- / zero-extended to XLEN.
    - H / HU: 16 bits, sign- / zero-extended.
    - W: sign-extended from bit 31. WU: zero-extended.
    - D: full XLEN word.
  - With XLEN=32, W, WU and D all return the full word.
  - Width 111 is treated as W.
- Error responses:
  - ld_rsp_err_i on a live response pops the entry and sets wb_valid_o=1, wb_we_rd_o=0.
  - ld_err_o pulses 1 and wb_rd_addr_o carries the entry's rd.
- Writeback register (one cycle latency, from the accept cycle to the outputs):
  - Load: wb_valid_o=1; wb_we_rd_o = !err && rd!=0; wb_rd_addr_o = entry rd; wb_rd_data_o = formatted data.
  - EX: wb_valid_o=1; wb_we_rd_o = ex_we_rd_i && rd!=0; wb_rd_data_o = ex_result_i.
  - Neither: wb_valid_o=0 and wb_we_rd_o=0; address and data hold their previous values.
- x0: never written, i.e. wb_we_rd_o=0 whenever rd==0.
- Reset mid-operation: everything returns to reset values in the next cycle; in-flight responses are not counted for discard.

Test Plan:
1. XLEN=32: push {rd=5, LB, off=3}, then response 0x80_11_22_33 -> one cycle later wb_we_rd_o=1, rd=5, data 0xFFFFFF80.
2. Push 4 loads (DEPTH=4) -> ld_req_ready_o=0 and pending_o=4; a 5th request is stalled. Responses in order -> rd 1,2,3,4 written in sequence and pointers wrap cleanly on a following push.
3. Load response and EX result in the same cycle -> load written first and ex_ready_o=0; the EX result is written the next cycle.
4. 3 loads outstanding, flush_i, then 3 responses -> no writebacks and ld_rsp_ready_o=1 for all three. A new load pushed after flush gets its own (4th) response written correctly.
5. Response with ld_rsp_err_i=1 on rd=7 -> ld_err_o pulses, wb_we_rd_o=0, wb_rd_addr_o=7.
6. XLEN=64: LWU at off=4 with data 0x8000_0001_xxxx_xxxx -> 0x0000_0000_8000_0001. LW with the same data -> 0xFFFF_FFFF_8000_0001. Any load to rd=0 -> wb_we_rd_o=0.

Source files
------------

// File: rtl/wb_lsu_queue.sv
// -----------------------------------------------------------------------------
// wb_lsu_queue
//
// Writeback stage for a core whose LSU can have up to DEPTH loads in flight.
// Load metadata (rd, width, byte offset) is queued in issue order.
// Each response pops the head entry. The raw bus word is aligned and
// sign/zero-extended, then merged with EX results onto a single registered
// register-file write port. A returning load always wins over EX.
//
// A flush empties the queue. Loads that were already on the bus still return,
// so they are added to a discard counter, and the matching responses are
// swallowed without any writeback.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   ex_*                 EX result and its handshake (ex_ready_o)
//   ld_req_*             load issue: push metadata into the queue
//   ld_rsp_*             load response from the bus, in issue order
//   flush_i              drop all outstanding loads
//   wb_*                 registered register-file write port
//   ld_err_o             one-cycle pulse: load returned a bus error
//   pending_o            number of live entries in the queue
// -----------------------------------------------------------------------------
module wb_lsu_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       ex_valid_i,
    input  logic                       ex_we_rd_i,
    input  logic [4:0]                 ex_rd_addr_i,
    input  logic [XLEN-1:0]            ex_result_i,
    output logic                       ex_ready_o,

    input  logic                       ld_req_valid_i,
    output logic                       ld_req_ready_o,
    input  logic [4:0]                 ld_req_rd_addr_i,
    input  logic [2:0]                 ld_req_width_i,
    input  logic [$clog2(XLEN/8)-1:0]  ld_req_offset_i,

    input  logic                       ld_rsp_valid_i,
    output logic                       ld_rsp_ready_o,
    input  logic [XLEN-1:0]            ld_rsp_data_i,
    input  logic                       ld_rsp_err_i,

    input  logic                       flush_i,

    output logic                       wb_valid_o,
    output logic                       wb_we_rd_o,
    output logic [4:0]                 wb_rd_addr_o,
    output logic [XLEN-1:0]            wb_rd_data_o,
    output logic                       ld_err_o,
    output logic [$clog2(DEPTH):0]     pending_o
);

    localparam int OW = $clog2(XLEN/8);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Discard can grow across back-to-back flushes when responses lag behind.
    // The extra headroom covers many queue-fulls of stale loads.
    localparam int DW = CW + 4;

    logic [4:0]    q_rd    [DEPTH];
    logic [2:0]    q_width [DEPTH];
    logic [OW-1:0] q_off   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [DW-1:0] discard;

    logic          full;
    logic          discarding;
    logic          live_rsp;
    logic          drop_rsp;
    logic          push;
    logic          ex_take;

    logic [4:0]      head_rd;
    logic [2:0]      head_width;
    logic [OW-1:0]   head_off;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ld_data;

    assign full       = (count == CW'(DEPTH));
    assign discarding = (discard != '0);
    assign live_rsp   = ld_rsp_valid_i && !discarding && (count != '0);
    assign drop_rsp   = ld_rsp_valid_i && discarding;
    assign push       = ld_req_valid_i && ld_req_ready_o;
    assign ex_take    = ex_valid_i && !live_rsp;

    assign ld_req_ready_o = !full && !flush_i;
    assign ld_rsp_ready_o = (count != '0) || discarding;
    assign ex_ready_o     = !live_rsp;
    assign pending_o      = count;

    assign head_rd    = q_rd[rd_ptr];
    assign head_width = q_width[rd_ptr];
    assign head_off   = q_off[rd_ptr];

    // Move the addressed byte lane down to bit 0, then extend by access width.
    // Width 111 is not a legal load; it is handled like a W load.
    always_comb begin
        shifted = ld_rsp_data_i >> {head_off, 3'b000};
        case (head_width)
            3'b000:  ld_data = XLEN'($signed(shifted[7:0]));
            3'b100:  ld_data = XLEN'(shifted[7:0]);
            3'b001:  ld_data = XLEN'($signed(shifted[15:0]));
            3'b101:  ld_data = XLEN'(shifted[15:0]);
            3'b110:  ld_data = XLEN'(shifted[31:0]);
            3'b011:  ld_data = shifted;
            default: ld_data = XLEN'($signed(shifted[31:0]));
        endcase
    end

    // Queue storage carries no control meaning, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]    <= ld_req_rd_addr_i;
            q_width[wr_ptr] <= ld_req_width_i;
            q_off[wr_ptr]   <= ld_req_offset_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            discard <= '0;
        end else if (flush_i) begin
            // Every entry still live after this cycle's pop has a response
            // on its way back that must be dropped. Push is already blocked.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            discard <= discard - DW'(drop_rsp) + DW'(count) - DW'(live_rsp);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (live_rsp) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count   <= count + CW'(push) - CW'(live_rsp);
            discard <= discard - DW'(drop_rsp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_o   <= 1'b0;
            wb_we_rd_o   <= 1'b0;
            wb_rd_addr_o <= '0;
            wb_rd_data_o <= '0;
            ld_err_o     <= 1'b0;
        end else if (live_rsp) begin
            wb_valid_o   <= 1'b1;
            wb_we_rd_o   <= !ld_rsp_err_i && (head_rd != 5'd0);
            wb_rd_addr_o <= head_rd;
            wb_rd_data_o <= ld_data;
            ld_err_o     <= ld_rsp_err_i;
        end else if (ex_take) begin
            wb_valid_o   <= 1'b1;
            wb_we_rd_o   <= ex_we_rd_i && (ex_rd_addr_i != 5'd0);
            wb_rd_addr_o <= ex_rd_addr_i;
            wb_rd_data_o <= ex_result_i;
            ld_err_o     <= 1'b0;
        end else begin
            wb_valid_o   <= 1'b0;
            wb_we_rd_o   <= 1'b0;
            ld_err_o     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_lsu_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_lsu_queue
//
// Drives identical control stimulus into a 32-bit and a 64-bit instance.
// Both are compared each cycle against a queue-based reference model that
// formats load data directly from the access width and byte offset.
// -----------------------------------------------------------------------------
module tb_wb_lsu_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_we;
    logic [4:0]  ex_rd;
    logic [63:0] ex_res;
    logic        req_valid;
    logic [4:0]  req_rd;
    logic [2:0]  req_width;
    logic [2:0]  req_off;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        flush;

    logic        ex_ready_32, req_ready_32, rsp_ready_32;
    logic        wb_valid_32, wb_we_32, ld_err_32;
    logic [4:0]  wb_addr_32;
    logic [31:0] wb_data_32;
    logic [2:0]  pending_32;

    logic        ex_ready_64, req_ready_64, rsp_ready_64;
    logic        wb_valid_64, wb_we_64, ld_err_64;
    logic [4:0]  wb_addr_64;
    logic [63:0] wb_data_64;
    logic [2:0]  pending_64;

    always #5 clk = ~clk;

    wb_lsu_queue #(.XLEN(32), .DEPTH(DEPTH)) dut_32 (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid), .ex_we_rd_i(ex_we), .ex_rd_addr_i(ex_rd),
        .ex_result_i(ex_res[31:0]), .ex_ready_o(ex_ready_32),
        .ld_req_valid_i(req_valid), .ld_req_ready_o(req_ready_32),
        .ld_req_rd_addr_i(req_rd), .ld_req_width_i(req_width),
        .ld_req_offset_i(req_off[1:0]),
        .ld_rsp_valid_i(rsp_valid), .ld_rsp_ready_o(rsp_ready_32),
        .ld_rsp_data_i(rsp_data[31:0]), .ld_rsp_err_i(rsp_err),
        .flush_i(flush),
        .wb_valid_o(wb_valid_32), .wb_we_rd_o(wb_we_32), .wb_rd_addr_o(wb_addr_32),
        .wb_rd_data_o(wb_data_32), .ld_err_o(ld_err_32), .pending_o(pending_32)
    );

    wb_lsu_queue #(.XLEN(64), .DEPTH(DEPTH)) dut_64 (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid), .ex_we_rd_i(ex_we), .ex_rd_addr_i(ex_rd),
        .ex_result_i(ex_res), .ex_ready_o(ex_ready_64),
        .ld_req_valid_i(req_valid), .ld_req_ready_o(req_ready_64),
        .ld_req_rd_addr_i(req_rd), .ld_req_width_i(req_width),
        .ld_req_offset_i(req_off),
        .ld_rsp_valid_i(rsp_valid), .ld_rsp_ready_o(rsp_ready_64),
        .ld_rsp_data_i(rsp_data), .ld_rsp_err_i(rsp_err),
        .flush_i(flush),
        .wb_valid_o(wb_valid_64), .wb_we_rd_o(wb_we_64), .wb_rd_addr_o(wb_addr_64),
        .wb_rd_data_o(wb_data_64), .ld_err_o(ld_err_64), .pending_o(pending_64)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the outstanding loads as a plain queue, plus a count of
    // stale responses still expected from the bus.
    typedef struct {
        logic [4:0] rd;
        logic [2:0] w;
        logic [2:0] off;
    } ent_t;

    ent_t        q[$];
    int          disc;
    logic        e_valid, e_we, e_err;
    logic [4:0]  e_addr;
    logic [31:0] e_d32;
    logic [63:0] e_d64;

    function automatic logic [63:0] fmt(input int xl, input logic [2:0] w,
                                        input logic [2:0] off, input logic [63:0] d);
        logic [63:0] s, r;
        if (xl == 32) s = {32'h0, d[31:0]} >> (8 * off[1:0]);
        else          s = d >> (8 * off);
        case (w)
            3'd0:    r = {{56{s[7]}}, s[7:0]};
            3'd4:    r = {56'h0, s[7:0]};
            3'd1:    r = {{48{s[15]}}, s[15:0]};
            3'd5:    r = {48'h0, s[15:0]};
            3'd6:    r = {32'h0, s[31:0]};
            3'd3:    r = s;
            default: r = {{32{s[31]}}, s[31:0]};
        endcase
        return (xl == 32) ? {32'h0, r[31:0]} : r;
    endfunction

    task automatic idle();
        rst = 0; ex_valid = 0; ex_we = 0; ex_rd = 0; ex_res = 0;
        req_valid = 0; req_rd = 0; req_width = 0; req_off = 0;
        rsp_valid = 0; rsp_data = 0; rsp_err = 0; flush = 0;
    endtask

    // Called just after a falling edge with inputs driven; returns at the
    // next falling edge with registered outputs checked.
    task automatic step();
        bit live, drop, push, rq_rdy, rs_rdy;
        ent_t e;
        logic [63:0] f;
        #1;
        if (rst) begin
            q.delete(); disc = 0;
            e_valid = 0; e_we = 0; e_err = 0; e_addr = 0; e_d32 = 0; e_d64 = 0;
        end else begin
            rq_rdy = (q.size() < DEPTH) && !flush;
            rs_rdy = (q.size() != 0) || (disc != 0);
            live   = rsp_valid && (disc == 0) && (q.size() != 0);
            drop   = rsp_valid && (disc != 0);
            push   = req_valid && rq_rdy;
            check("req_ready32", req_ready_32, rq_rdy);
            check("req_ready64", req_ready_64, rq_rdy);
            check("rsp_ready32", rsp_ready_32, rs_rdy);
            check("rsp_ready64", rsp_ready_64, rs_rdy);
            check("ex_ready32", ex_ready_32, !live);
            check("ex_ready64", ex_ready_64, !live);
            if (live) begin
                e = q.pop_front();
                e_valid = 1; e_we = !rsp_err && (e.rd != 0); e_err = rsp_err; e_addr = e.rd;
                f = fmt(32, e.w, e.off, rsp_data); e_d32 = f[31:0];
                e_d64 = fmt(64, e.w, e.off, rsp_data);
            end else if (ex_valid) begin
                e_valid = 1; e_we = ex_we && (ex_rd != 0); e_err = 0; e_addr = ex_rd;
                e_d32 = ex_res[31:0]; e_d64 = ex_res;
            end else begin
                e_valid = 0; e_we = 0; e_err = 0;
            end
            if (flush) begin
                disc = disc - int'(drop) + q.size();
                q.delete();
            end else begin
                disc = disc - int'(drop);
                if (push) q.push_back('{rd: req_rd, w: req_width, off: req_off});
            end
        end
        @(negedge clk);
        check("wb_valid32", wb_valid_32, e_valid);
        check("wb_valid64", wb_valid_64, e_valid);
        check("wb_we32", wb_we_32, e_we);
        check("wb_we64", wb_we_64, e_we);
        check("ld_err32", ld_err_32, e_err);
        check("ld_err64", ld_err_64, e_err);
        check("wb_addr32", wb_addr_32, e_addr);
        check("wb_addr64", wb_addr_64, e_addr);
        check("wb_data32", wb_data_32, e_d32);
        check("wb_data64", wb_data_64, e_d64);
        check("pending32", pending_32, q.size());
        check("pending64", pending_64, q.size());
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] w, input logic [2:0] off);
        idle(); req_valid = 1; req_rd = rd; req_width = w; req_off = off; step();
    endtask

    task automatic respond(input logic [63:0] d, input logic err);
        idle(); rsp_valid = 1; rsp_data = d; rsp_err = err; step();
    endtask

    initial begin
        idle();
        @(negedge clk);
        rst = 1; step(); step();
        check("reset_pending", pending_32, 0);
        check("reset_wb_valid", wb_valid_32, 0);

        // LB at offset 3 of 0x80112233
        load(5, 3'b000, 3);
        respond(64'h0000_0000_8011_2233, 0);
        check("lb_data", wb_data_32, 32'hFFFF_FF80);
        check("lb_we", wb_we_32, 1);
        check("lb_addr", wb_addr_32, 5);

        // fill, stall a fifth request, drain in order, then wrap
        for (int i = 1; i <= 4; i++) load(5'(i), 3'b010, 0);
        check("full_ready", req_ready_32, 0);
        check("full_pending", pending_32, 4);
        load(9, 3'b010, 0);
        for (int i = 1; i <= 4; i++) begin
            respond({$urandom, $urandom}, 0);
            check("order_addr", wb_addr_32, 5'(i));
        end
        load(6, 3'b001, 2);
        respond({$urandom, $urandom}, 0);
        check("wrap_addr", wb_addr_32, 6);

        // load response collides with an EX result
        load(10, 3'b010, 0);
        idle(); rsp_valid = 1; rsp_data = 64'h1234_5678;
        ex_valid = 1; ex_we = 1; ex_rd = 11; ex_res = 64'hABCD; step();
        check("coll_ld_addr", wb_addr_32, 10);
        idle(); ex_valid = 1; ex_we = 1; ex_rd = 11; ex_res = 64'hABCD; step();
        check("coll_ex_addr", wb_addr_32, 11);
        check("coll_ex_data", wb_data_32, 32'hABCD);

        // flush with three outstanding; stale responses are swallowed
        for (int i = 0; i < 3; i++) load(5'(20 + i), 3'b010, 0);
        idle(); flush = 1; step();
        for (int i = 0; i < 3; i++) begin
            respond({$urandom, $urandom}, 0);
            check("flush_no_wb", wb_valid_32, 0);
        end
        load(12, 3'b010, 0);
        respond(64'h0000_0000_CAFE_F00D, 0);
        check("post_flush_addr", wb_addr_32, 12);
        check("post_flush_data", wb_data_32, 32'hCAFE_F00D);

        // error response
        load(7, 3'b010, 0);
        respond(64'h5555, 1);
        check("err_pulse", ld_err_32, 1);
        check("err_we", wb_we_32, 0);
        check("err_addr", wb_addr_32, 7);
        idle(); step();
        check("err_pulse_end", ld_err_32, 0);

        // 64-bit word loads at offset 4, and rd=0
        load(3, 3'b110, 4);
        respond(64'h8000_0001_DEAD_BEEF, 0);
        check("lwu64", wb_data_64, 64'h0000_0000_8000_0001);
        load(3, 3'b010, 4);
        respond(64'h8000_0001_DEAD_BEEF, 0);
        check("lw64", wb_data_64, 64'hFFFF_FFFF_8000_0001);
        load(0, 3'b011, 0);
        respond(64'h1, 0);
        check("x0_we", wb_we_64, 0);

        // random traffic, with one reset in the middle
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst       = (n == 1500);
            flush     = ($urandom_range(0, 29) == 0);
            req_valid = ($urandom_range(0, 99) < 45);
            req_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            req_width = 3'($urandom);
            req_off   = 3'($urandom);
            rsp_valid = ($urandom_range(0, 99) < 50);
            rsp_data  = {$urandom, $urandom};
            rsp_err   = ($urandom_range(0, 9) == 0);
            ex_valid  = ($urandom_range(0, 99) < 40);
            ex_we     = ($urandom_range(0, 3) != 0);
            ex_rd     = 5'($urandom);
            ex_res    = {$urandom, $urandom};
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
